// File: rtl/pdm_stream_printer_pkg.sv
// Shared constants and types for the PDM capture / UART streaming block.
package pdm_stream_printer_pkg;

  // UART command bytes.
  localparam logic [7:0] CmdStart = 8'h53;  // 'S'
  localparam logic [7:0] CmdStop  = 8'h50;  // 'P'
  localparam logic [7:0] CmdClear = 8'h43;  // 'C'

  // Header byte sent at the start of every frame.
  localparam logic [7:0] SyncByte = 8'hA5;

  // Transmit sequencer states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSync = 2'd1,
    StData = 2'd2,
    StHold = 2'd3
  } tx_state_e;

  // Number of sample events needed to fill one byte.
  function automatic int unsigned events_per_byte(input int unsigned lines);
    return 8 / lines;
  endfunction

endpackage

// File: rtl/pdm_stream_printer_fifo.sv
// Synchronous byte FIFO with async-cleared pointers; push and pop may share a cycle.
module pdm_byte_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AddrW:0]   wptr_q, wptr_d;
  logic [AddrW:0]   rptr_q, rptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);

  // A pop frees a slot in the same cycle, so a push on a full FIFO still lands.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign rdata_o = mem_q[rptr_q[AddrW-1:0]];

  // Pointer advance.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AddrW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/pdm_stream_printer.sv
// PDM microphone capture: clock generation, sampling, byte packing, buffering and
// framed streaming over the UART byte handshake, controlled by UART commands.
module pdm_stream_printer
  import pdm_stream_printer_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 25,
  parameter int unsigned NUM_LINES  = 1,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FRAME_LEN  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 pdm_clk,
  input  logic [NUM_LINES-1:0] pdm_data,
  input  logic [7:0]           rx_data,
  input  logic                 new_rx_data,
  output logic [7:0]           tx_data,
  output logic                 new_tx_data,
  input  logic                 tx_busy,
  output logic                 enabled,
  output logic                 overflow,
  output logic [7:0]           drop_count
);

  localparam int unsigned      DivW       = $clog2(CLK_DIV);
  localparam logic [DivW-1:0]  DivLast    = DivW'(CLK_DIV - 1);
  localparam int unsigned      EvtPerByte = events_per_byte(NUM_LINES);
  localparam int unsigned      EvtW       = $clog2(EvtPerByte);
  localparam logic [EvtW-1:0]  EvtLast    = EvtW'(EvtPerByte - 1);
  localparam logic [7:0]       FrameLast  = 8'(FRAME_LEN - 1);

  // Command decode
  logic cmd_start, cmd_stop, cmd_clear;
  logic start_now;
  logic run;
  logic enabled_q, enabled_d;

  // Clock divider and capture
  logic [DivW-1:0]      div_q, div_d;
  logic                 pdm_clk_q, pdm_clk_d;
  logic                 sample_evt;
  logic [NUM_LINES-1:0] sync1_q, sync2_q;
  logic [NUM_LINES-1:0] line_bits;
  logic [7:0]           shift_q, shift_d, shift_next;
  logic [EvtW-1:0]      evt_cnt_q, evt_cnt_d;
  logic                 byte_push;

  // Buffer and overflow tracking
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_rdata;
  logic       drop;
  logic       overflow_q, overflow_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Transmit sequencer
  tx_state_e  state_q, state_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       sync_done_q, sync_done_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       new_tx_q, new_tx_d;

  assign cmd_start = new_rx_data && (rx_data == CmdStart);
  assign cmd_stop  = new_rx_data && (rx_data == CmdStop);
  assign cmd_clear = new_rx_data && (rx_data == CmdClear);
  assign start_now = cmd_start && !enabled_q;
  // A stop command halts capture in the cycle it arrives, not one cycle later.
  assign run       = enabled_q && !cmd_stop;

  // Enable flag follows start/stop commands.
  always_comb begin
    enabled_d = enabled_q;
    if (cmd_stop) begin
      enabled_d = 1'b0;
    end else if (cmd_start) begin
      enabled_d = 1'b1;
    end
  end

  // Divider: toggles pdm_clk every CLK_DIV cycles; the toggle cycle is also the sample point.
  always_comb begin
    div_d      = div_q;
    pdm_clk_d  = pdm_clk_q;
    sample_evt = 1'b0;
    if (!run) begin
      div_d     = '0;
      pdm_clk_d = 1'b0;
    end else if (div_q == DivLast) begin
      div_d      = '0;
      pdm_clk_d  = !pdm_clk_q;
      sample_evt = 1'b1;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  // Line 0 lands in the most significant position of each NUM_LINES-bit chunk.
  always_comb begin
    line_bits = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      line_bits[NUM_LINES-1-i] = sync2_q[i];
    end
  end

  assign shift_next = (shift_q << NUM_LINES) | 8'(line_bits);

  // Packer: pdm_clk always restarts low, so the first event is an odd-channel
  // (rising-half) sample and byte alignment follows from it.
  always_comb begin
    shift_d   = shift_q;
    evt_cnt_d = evt_cnt_q;
    byte_push = 1'b0;
    if (!run) begin
      shift_d   = '0;
      evt_cnt_d = '0;
    end else if (sample_evt) begin
      shift_d = shift_next;
      if (evt_cnt_q == EvtLast) begin
        evt_cnt_d = '0;
        byte_push = 1'b1;
      end else begin
        evt_cnt_d = evt_cnt_q + 1'b1;
      end
    end
  end

  // A same-cycle pop makes room, so only a push into a full FIFO without a pop is lost.
  assign drop = byte_push && fifo_full && !fifo_pop;

  // Sticky overflow flag and saturating drop counter.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (cmd_clear) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  // TX sequencer: strobe and data are registered, so they appear the cycle after IDLE decides.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    sync_done_d = sync_done_q;
    tx_data_d   = tx_data_q;
    new_tx_d    = 1'b0;
    fifo_pop    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!tx_busy && !fifo_empty) begin
          new_tx_d = 1'b1;
          if (frame_cnt_q == 8'd0 && !sync_done_q) begin
            state_d   = StSync;
            tx_data_d = SyncByte;
          end else begin
            // Head is stable until StData pops it.
            state_d   = StData;
            tx_data_d = fifo_rdata;
          end
        end
      end
      StSync: begin
        sync_done_d = 1'b1;
        state_d     = StHold;
      end
      StData: begin
        fifo_pop = 1'b1;
        if (frame_cnt_q == FrameLast) begin
          frame_cnt_d = '0;
          sync_done_d = 1'b0;
        end else begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
        state_d = StHold;
      end
      // Gives the UART one cycle to raise tx_busy.
      StHold: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (start_now) begin
      frame_cnt_d = '0;
      sync_done_d = 1'b0;
    end
  end

  // Two-flop synchroniser for the asynchronous mic data lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pdm_data;
      sync2_q <= sync1_q;
    end
  end

  // Control, capture and overflow state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enabled_q  <= 1'b0;
      div_q      <= '0;
      pdm_clk_q  <= 1'b0;
      shift_q    <= '0;
      evt_cnt_q  <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      enabled_q  <= enabled_d;
      div_q      <= div_d;
      pdm_clk_q  <= pdm_clk_d;
      shift_q    <= shift_d;
      evt_cnt_q  <= evt_cnt_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Transmit sequencer state and registered UART outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      frame_cnt_q <= '0;
      sync_done_q <= 1'b0;
      tx_data_q   <= '0;
      new_tx_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      sync_done_q <= sync_done_d;
      tx_data_q   <= tx_data_d;
      new_tx_q    <= new_tx_d;
    end
  end

  pdm_byte_fifo #(
    .Width (8),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (byte_push),
    .wdata_i (shift_next),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign pdm_clk     = pdm_clk_q;
  assign tx_data     = tx_data_q;
  assign new_tx_data = new_tx_q;
  assign enabled     = enabled_q;
  assign overflow    = overflow_q;
  assign drop_count  = drop_cnt_q;

endmodule
